// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver: RV32I branch funct3 codes and BHT counter type.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t CTR_RESET = 2'b01;
    localparam bht_ctr_t CTR_MAX   = 2'b11;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decode: funct3 plus ALU flags -> {taken, legal}.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_bit_m,
    input  logic       i_bit_mu,
    output logic       o_taken,
    output logic       o_legal
);

    always_comb begin
        o_taken = 1'b0;
        o_legal = 1'b1;
        case (i_funct3)
            F3_BEQ:  o_taken = i_zero;
            F3_BNE:  o_taken = ~i_zero;
            F3_BLT:  o_taken = i_bit_m;
            F3_BGE:  o_taken = ~i_bit_m;
            F3_BLTU: o_taken = i_bit_mu;
            F3_BGEU: o_taken = ~i_bit_mu;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver_bht.sv
// Branch/jump resolution into the PC-source select plus a 2-bit saturating-counter BHT.
// Optional BRANCH_STATS_EN adds saturating branch and mispredict counters.
module branch_resolver_bht
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            branch_i,
    input  logic            tipo_j_i,
    input  logic [2:0]      branch_ctrl_i,
    input  logic            zero_flag_i,
    input  logic            bit_m_i,
    input  logic            bit_mu_i,
    input  logic [XLEN-1:0] pc_resolve_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            pred_taken_o,
    output logic            pc_source_o,
    output logic            mispredict_o,
    output logic            brflag_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispred_cnt_o
`endif
);

    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

    logic                 w_taken;
    logic                 w_legal;
    logic                 w_resolve;
    logic [BHT_IDX_W-1:0] w_ridx;
    logic [BHT_IDX_W-1:0] w_fidx;
    bht_ctr_t             w_ctr_cur;
    bht_ctr_t             r_bht [BHT_ENTRIES];

    branch_cond_eval u_cond_eval (
        .i_funct3 (branch_ctrl_i),
        .i_zero   (zero_flag_i),
        .i_bit_m  (bit_m_i),
        .i_bit_mu (bit_mu_i),
        .o_taken  (w_taken),
        .o_legal  (w_legal)
    );

    // Upper PC bits alias onto the same counter; pc[1:0] is always ignored.
    logic w_unused_pc;
    assign w_unused_pc = ^{pc_resolve_i[XLEN-1:BHT_IDX_W+2], pc_resolve_i[1:0],
                           fetch_pc_i[XLEN-1:BHT_IDX_W+2], fetch_pc_i[1:0]};

    assign w_ridx    = pc_resolve_i[BHT_IDX_W+1:2];
    assign w_fidx    = fetch_pc_i[BHT_IDX_W+1:2];
    assign w_resolve = valid_i & branch_i & w_legal;
    assign w_ctr_cur = r_bht[w_ridx];

    always_comb begin
        pc_source_o  = 1'b0;
        mispredict_o = 1'b0;
        brflag_o     = 1'b0;
        if (valid_i) begin
            // A conditional branch decides alone, even if the jump flag is also set.
            if (branch_i) begin
                pc_source_o  = w_legal & w_taken;
                mispredict_o = w_legal & (w_taken != pred_taken_i);
                brflag_o     = ~w_legal;
            end else begin
                pc_source_o  = tipo_j_i;
            end
        end
    end

    assign pred_taken_o = r_bht[w_fidx][1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bht <= '{default: CTR_RESET};
        end else if (w_resolve) begin
            if (w_taken && (w_ctr_cur != CTR_MAX)) begin
                r_bht[w_ridx] <= w_ctr_cur + 2'b01;
            end else if (!w_taken && (w_ctr_cur != 2'b00)) begin
                r_bht[w_ridx] <= w_ctr_cur - 2'b01;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolve && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (mispredict_o && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;
`endif

endmodule

// File: doc/branch_resolver_bht.md
Name: branch_resolver_bht

Overview:
- Next-generation branch resolution block for the RV32I core.
- Resolves conditional branches (all six RV32I funct3 encodings) and unconditional jumps into the PC-source select.
- Adds a parametrised branch history table (BHT) of 2-bit saturating counters:
  - fetch reads a direction prediction combinationally;
  - resolution updates the table on the clock edge and flags mispredictions.
- Sits between the ALU flag outputs and the PC-select mux; the BHT read port faces the fetch stage.

Parameters:
- XLEN, 32, PC width in bits.
- BHT_ENTRIES, 64, number of counters; power of 2, minimum 2.
- BHT_IDX_W, $clog2(BHT_ENTRIES), derived; index = pc[BHT_IDX_W+1:2].

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- valid_i  in  1  resolving instruction is valid this cycle.
- branch_i  in  1  conditional branch.
- tipo_j_i  in  1  unconditional jump (JAL/JALR).
- branch_ctrl_i  in  3  funct3 of the branch.
- zero_flag_i  in  1  ALU result == 0.
- bit_m_i  in  1  signed rs1 < rs2.
- bit_mu_i  in  1  unsigned rs1 < rs2.
- pc_resolve_i  in  XLEN  PC of the resolving instruction.
- pred_taken_i  in  1  prediction carried down from fetch for this instruction.
- fetch_pc_i  in  XLEN  PC being fetched.
- pred_taken_o  out  1  BHT prediction for fetch_pc_i (counter MSB).
- pc_source_o  out  1  1 = take branch/jump target.
- mispredict_o  out  1  conditional-branch direction differs from pred_taken_i.
- brflag_o  out  1  illegal branch funct3 (010/011) presented with branch_i.

Behaviour:
- Clock and reset:
  - Single clock, posedge clk_i.
  - rst_i is synchronous and active-high; while asserted, every BHT counter loads 2'b01 (weakly not-taken).
- Taken decode (combinational): 000 BEQ zero; 001 BNE !zero; 100 BLT bit_m; 101 BGE !bit_m; 110 BLTU bit_mu; 111 BGEU !bit_mu; 010/011 illegal, taken = 0.
- pc_source_o (combinational, no latency):
  - valid_i & branch_i & legal & taken: 1.
  - else valid_i & tipo_j_i: 1.
  - else 0.
  - valid_i = 0 forces pc_source_o = 0, mispredict_o = 0, brflag_o = 0.
- branch_i and tipo_j_i both high: branch_i has priority.
- brflag_o = valid_i & branch_i & funct3 ∈ {010, 011}; no other effect beyond pc_source_o = 0.
- mispredict_o:
  - Equals valid_i & branch_i & legal & (taken != pred_taken_i).
  - Jumps never raise mispredict_o.
- pred_taken_o:
  - Equals bht[fetch_pc_i idx][1], combinational.
  - Reads the pre-update value; there is no write-to-read bypass when the fetch and resolve indices collide in the same cycle.
- BHT update, on the clock edge when valid_i & branch_i & legal & !rst_i:
  - Taken: counter increments, saturating at 2'b11.
  - Not taken: counter decrements, saturating at 2'b00.
  - Jumps and illegal encodings do not update.
- Reset during an update cycle: reset wins; the entry ends at 01.
- Aliasing: PCs differing only above bit BHT_IDX_W+1 share one counter; this is accepted behaviour.
- Bits pc[1:0] are ignored.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs branch_cnt_o [31:0] and mispred_cnt_o [31:0].
  - branch_cnt_o increments on each cycle with a legal, valid conditional branch; mispred_cnt_o increments on each cycle with mispredict_o = 1.
  - Both saturate at 32'hFFFF_FFFF and clear on rst_i.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package branch_pkg:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU;
  - 2-bit counter typedef bht_ctr_t;
  - constants CTR_RESET = 2'b01 and CTR_MAX = 2'b11.
- One sub-module, branch_cond_eval: the purely combinational funct3 + flags -> {taken, legal} decode.
- The table, update logic and optional stats stay in the top module.

Test Plan:
- Reset: assert rst_i for 1 cycle, sweep fetch_pc_i over all indices -> pred_taken_o = 0 everywhere.
- Decode: BLTU, bit_mu_i = 1, bit_m_i = 0, valid_i = 1 -> pc_source_o = 1; BGE with bit_m_i = 1 -> 0; JAL (tipo_j_i = 1) -> 1, mispredict_o = 0.
- Training: pc = 0x100, taken, pred_taken_i = 0, twice -> cycle 1 mispredict_o = 1, then counter 01->10->11; fetch_pc = 0x100 -> pred_taken_o = 1. Three not-taken -> counter 00, pred_taken_o = 0.
- Saturation and alias: with BHT_ENTRIES = 64, five taken at 0x100 keep counter at 11; one not-taken at 0x200 (same index 0) -> counter 10 for 0x100.
- Illegal and collision: funct3 = 010 -> brflag_o = 1, pc_source_o = 0, no BHT change. Same-cycle fetch and resolve at equal index -> pred_taken_o shows the old value, the new value the following cycle.
- BRANCH_STATS_EN: 10 branches with 3 mispredicts -> branch_cnt_o = 10, mispred_cnt_o = 3; rst_i -> both 0.
